system_key_in: RTL
==================

Name: system_key_in

Overview:
- Avalon-MM slave input port, the read-side counterpart of the 7-segment output PIOs.
- Samples push-buttons/switches (in_port) through a 2-flop synchronizer.
- Exposes live data, a per-bit edge-capture register and an interrupt mask to the Nios II CPU.
- Drives a level-sensitive irq into the system interconnect.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- EDGE_TYPE, 0, edge captured: 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 50000, stable-clock count before a bit change is accepted (used only with SYSTEM_KEY_IN_DEBOUNCE_EN).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  word address of the register.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  read data, zero-extended.
- irq  output  1  interrupt request, active-high level.

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. All flops clear on reset: sync1, sync2, prev, irq_mask, edge_capture, arm counter. readdata is 0 and irq is 0 during reset.
- Synchronizer: sync1 <= in_port; sync2 <= sync1. Filtered value din = sync2, or the debounced value (see Optional Feature).
- Register map (read latency 0; readdata is a combinational mux of registers; no wait states):
  - addr 0 DATA: RO; din zero-extended; writes ignored.
  - addr 1: reads 0; writes ignored.
  - addr 2 IRQ_MASK: RW; write when chipselect && !write_n; loads writedata[WIDTH-1:0].
  - addr 3 EDGE_CAPTURE: read returns capture bits. A write clears bit i where writedata[i]=1 (write-1-to-clear); other bits are unaffected.
- Edge detect: prev <= din every clock. Per-bit edge:
  - rising: din & ~prev.
  - falling: ~din & prev.
  - any: din ^ prev.
- Arm gating: edges are suppressed until a 2-bit arm counter reaches 3 (first 3 clocks after reset release). prev still tracks din during this window, so an input held high through reset causes no spurious capture.
- Capture: edge_capture[i] <= 1 on edge[i]. If an edge and a W1C clear hit the same bit in the same cycle, set wins.
- irq: irq = |(edge_capture & irq_mask), driven from registers and therefore glitch-free. Masking does not clear captures; unmasking a pending bit asserts irq next cycle.
- Latency (no debounce), in_port change sampled at clk edge N:
  - DATA reflects the change after edge N+1.
  - edge_capture bit and irq set after edge N+2.
- Reset asserted mid-operation clears captures, mask and arm; the block re-arms 3 clocks after release.

Optional Feature:
- Macro: SYSTEM_KEY_IN_DEBOUNCE_EN.
- Defined:
  - Per-bit counter of width $clog2(DEBOUNCE_CYCLES+1) sits between sync2 and din.
  - While sync2[i] != stable[i], the counter increments each clock. When it reaches DEBOUNCE_CYCLES-1, stable[i] <= sync2[i] and the counter clears.
  - Any cycle with sync2[i] == stable[i] clears the counter.
  - stable resets to 0. din = stable; latency grows by DEBOUNCE_CYCLES clocks.
- Undefined: din = sync2; no counters are instantiated.

Decomposition:
- Package system_key_in_pkg:
  - Constants ADDR_DATA=2'd0, ADDR_MASK=2'd2, ADDR_EDGE=2'd3.
  - EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2.
  - Arm count constant 3.
- Sub-module system_key_in_debounce: one bit, counter plus stable flop. Instantiated WIDTH times in a generate block under the macro.

Test Plan:
- Reset release with in_port=4'hF held: read addr 0 returns 32'h0000000F after 2 clocks. Read addr 3 returns 0; irq stays 0.
- EDGE_TYPE=0, mask=4'h1, in_port 0 -> 4'h1:
  - edge_capture=1 and irq=1 two clocks after the sampling edge.
  - Write 32'h1 to addr 3 -> capture 0, irq 0 next cycle.
- EDGE_TYPE=2, mask=0, toggle bit 2: capture=4'h4 while irq stays 0. Write mask 4'h4 -> irq=1 on the next clock.
- W1C of bit 0 in the same cycle as a new bit-0 edge: edge_capture[0] remains 1.
- Write addr 0 and addr 1 with 32'hFFFFFFFF: DATA still tracks in_port; addr 1 reads 0; mask unchanged.
- With SYSTEM_KEY_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES=8:
  - A 5-clock glitch on bit 1 causes no DATA change and no capture.
  - A 20-clock hold updates DATA 8 clocks after sync2 changes.

Source files
------------

// File: rtl/system_key_in_pkg.sv
// Shared register addresses, edge-type encodings and arm constant for system_key_in.
package system_key_in_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

  localparam logic [1:0] ARM_COUNT = 2'd3;

endpackage

// File: rtl/system_key_in_debounce.sv
// One-bit debouncer: the stable output follows raw only after it has differed
// for DEBOUNCE_CYCLES consecutive clocks.
module system_key_in_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Any cycle where raw agrees with stable restarts the qualification window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (raw != stable) begin
      if (cnt == CNT_LAST) begin
        stable <= raw;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/system_key_in.sv
// Avalon-MM input PIO with synchronizer, edge capture (W1C) and masked level irq.
// Optional per-bit debouncing is enabled with SYSTEM_KEY_IN_DEBOUNCE_EN.
module system_key_in
  import system_key_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clear_bits;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef SYSTEM_KEY_IN_DEBOUNCE_EN
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
    system_key_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (sync2[gi]),
      .stable (din[gi])
    );
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign din = sync2;
`endif

  always_comb begin
    edge_det = din & ~prev;
    if (EDGE_TYPE == int'(EDGE_FALLING)) begin
      edge_det = ~din & prev;
    end else if (EDGE_TYPE == int'(EDGE_ANY)) begin
      edge_det = din ^ prev;
    end
  end

  // prev keeps tracking during the arm window so a level held through reset is not seen as an edge
  assign armed      = (arm_cnt == ARM_COUNT);
  assign edge_hit   = armed ? edge_det : '0;
  assign wr_en      = chipselect && !write_n;
  assign clear_bits = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      arm_cnt      <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      prev <= din;
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
      if (wr_en && address == ADDR_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      // A new edge overrides a simultaneous write-1-to-clear on the same bit
      edge_capture <= (edge_capture & ~clear_bits) | edge_hit;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = din;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule
